// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU
// between two requesters, with multicycle hold for MUL.
module alu_share_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [1:0]       r0_op,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [1:0]       r1_op,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_z,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_z,
  output logic             busy
);

  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             own_q, own_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [1:0]       alu_op_q;
  logic [WIDTH-1:0] rsp_y_q;
  logic             rsp_z_q;
  logic             rsp_vld_q;

  logic             gnt_any;
  logic             gnt_sel;
  logic             accept;
  logic             capture;
  logic             rsp_hs;
  logic [WIDTH-1:0] req_a, req_b;
  logic [1:0]       req_op;

  // grant select: lone requester wins, contention follows rr pointer
  always_comb begin
    gnt_any = r0_valid | r1_valid;
    gnt_sel = 1'b0;
    unique case (1'b1)
      r0_valid && r1_valid:  gnt_sel = rr_q;
      !r0_valid && r1_valid: gnt_sel = 1'b1;
      default:               gnt_sel = 1'b0;
    endcase
  end

  assign accept   = (state_q == IDLE) && gnt_any;
  assign r0_ready = accept && !gnt_sel;
  assign r1_ready = accept && gnt_sel;

  // operand mux toward the ALU input registers
  always_comb begin
    req_a  = r0_a;
    req_b  = r0_b;
    req_op = r0_op;
    if (gnt_sel) begin
      req_a  = r1_a;
      req_b  = r1_b;
      req_op = r1_op;
    end
  end

  assign rsp_hs = own_q ? r1_rsp_ready : r0_rsp_ready;

  // next-state, hold counter, owner and rr pointer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    rr_d    = rr_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          own_d   = gnt_sel;
          cnt_d   = (req_op == OP_MUL) ? MUL_LD : 4'd0;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          state_d = IDLE;
          rr_d    = ~own_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      own_q   <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
    end
  end

  // ALU operands load only on accept and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 2'd0;
    end else if (accept) begin
      alu_a_q  <= req_a;
      alu_b_q  <= req_b;
      alu_op_q <= req_op;
    end
  end

  // response capture at the last hold cycle, release on owner handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_y_q   <= '0;
      rsp_z_q   <= 1'b0;
      rsp_vld_q <= 1'b0;
    end else if (capture) begin
      rsp_y_q   <= alu_y;
      rsp_z_q   <= alu_z;
      rsp_vld_q <= 1'b1;
    end else if (state_q == RESP && rsp_hs) begin
      rsp_vld_q <= 1'b0;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_z        = rsp_z_q;
  assign r0_rsp_valid = rsp_vld_q && !own_q;
  assign r1_rsp_valid = rsp_vld_q && own_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scoreboard bench with a
// behavioural ALU attached to the shared ALU port.
module tb_alu_share_arbiter;

  localparam int W  = 32;
  localparam int MC = 3;

  logic         clk;
  logic         rst_n;
  logic         r0_valid, r1_valid;
  logic         r0_ready, r1_ready;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [1:0]   r0_op, r1_op;
  logic         r0_rsp_valid, r1_rsp_valid;
  logic         r0_rsp_ready, r1_rsp_ready;
  logic [W-1:0] rsp_y;
  logic         rsp_z;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [1:0]   alu_op;
  logic         alu_z;
  logic         busy;

  alu_share_arbiter #(
    .WIDTH      (W),
    .MUL_CYCLES (MC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r0_valid     (r0_valid),
    .r0_ready     (r0_ready),
    .r0_a         (r0_a),
    .r0_b         (r0_b),
    .r0_op        (r0_op),
    .r0_rsp_valid (r0_rsp_valid),
    .r0_rsp_ready (r0_rsp_ready),
    .r1_valid     (r1_valid),
    .r1_ready     (r1_ready),
    .r1_a         (r1_a),
    .r1_b         (r1_b),
    .r1_op        (r1_op),
    .r1_rsp_valid (r1_rsp_valid),
    .r1_rsp_ready (r1_rsp_ready),
    .rsp_y        (rsp_y),
    .rsp_z        (rsp_z),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_y        (alu_y),
    .alu_z        (alu_z),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    unique case (alu_op)
      2'd1:    alu_y = alu_a * alu_b;
      2'd2:    alu_y = alu_b;
      default: alu_y = alu_a + alu_b;
    endcase
    alu_z = (alu_y == '0);
  end

  typedef struct {
    logic         own;
    logic [W-1:0] y;
    logic         z;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  bit           grants[$];
  logic [W-1:0] e0, e1;
  int           cyc_n;
  int           n_chk;
  int           n_pass;
  bit           acc_hit;
  bit           seen;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, need %0h", tag, obs, exp);
  endtask

  // sample at mid-cycle, log accepts/responses, then advance one edge
  task automatic cyc();
    exp_t e;
    #1;
    check("one_ready", r0_ready & r1_ready, 0);
    if (r0_valid && r0_ready) begin
      sb.push_back('{1'b0, e0, (e0 == '0), cyc_n,
                     (r0_op == 2'd1) ? 1 + MC : 2});
      grants.push_back(1'b0);
      acc_hit = 1'b1;
    end
    if (r1_valid && r1_ready) begin
      sb.push_back('{1'b1, e1, (e1 == '0), cyc_n,
                     (r1_op == 2'd1) ? 1 + MC : 2});
      grants.push_back(1'b1);
      acc_hit = 1'b1;
    end
    if (r0_rsp_valid || r1_rsp_valid) begin
      if (sb.size() == 0) begin
        check("stale_rsp", {r1_rsp_valid, r0_rsp_valid}, 0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("rsp_lat", cyc_n - sb[0].acc, sb[0].lat);
          check("rsp_owner", {r1_rsp_valid, r0_rsp_valid},
                sb[0].own ? 2 : 1);
        end
        if (sb[0].own ? r1_rsp_ready : r0_rsp_ready) begin
          e = sb.pop_front();
          check("rsp_y", rsp_y, e.y);
          check("rsp_z", rsp_z, e.z);
          seen = 1'b0;
        end
      end
    end
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic issue(input bit req,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [1:0] op,
                       input logic [W-1:0] ey);
    int n;
    n = 0;
    if (!req) begin
      r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op; e0 = ey;
    end else begin
      r1_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op; e1 = ey;
    end
    acc_hit = 1'b0;
    while (!acc_hit && n < 50) begin
      cyc();
      n++;
    end
    check("accept", acc_hit, 1);
    if (!req) r0_valid = 1'b0;
    else      r1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc_n = 0;
    seen = 1'b0; acc_hit = 1'b0;
    e0 = '0; e1 = '0;
    rst_n = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_a = '0; r0_b = '0; r0_op = 2'd0;
    r1_a = '0; r1_b = '0; r1_op = 2'd0;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", {r1_ready, r0_ready}, 0);
    check("rst_rspv", {r1_rsp_valid, r0_rsp_valid}, 0);
    check("rst_alu", {alu_a, alu_b}, 0);
    check("rst_rsp_y", rsp_y, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single ADD from r0
    r0_rsp_ready = 1'b1;
    r1_rsp_ready = 1'b1;
    r0_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd7; r0_op = 2'd0;
    e0 = 32'd12;
    #1;
    check("add_r0_ready", r0_ready, 1);
    check("add_r1_ready", r1_ready, 0);
    cyc();
    r0_valid = 1'b0;
    check("add_busy", busy, 1);
    cyc();
    cyc();
    check("add_rspv_off", {r1_rsp_valid, r0_rsp_valid}, 0);
    check("add_idle", busy, 0);

    // MUL hold and truncation from r1
    issue(1'b1, 32'h10000, 32'h10000, 2'd1, 32'h0);
    for (int i = 0; i < MC; i++) begin
      check("mul_alu_a", alu_a, 32'h10000);
      check("mul_alu_b", alu_b, 32'h10000);
      check("mul_alu_op", alu_op, 1);
      check("mul_rspv", r1_rsp_valid, 0);
      cyc();
    end
    drain(2);

    // contention: alternating grants
    grants.delete();
    r0_valid = 1'b1; r0_a = 32'd0; r0_b = 32'hAB; r0_op = 2'd2;
    e0 = 32'hAB;
    r1_valid = 1'b1; r1_a = 32'd1; r1_b = 32'd1; r1_op = 2'd0;
    e1 = 32'd2;
    drain(12);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    check("rr_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++)
      check("rr_order", grants[i], i % 2);
    drain(4);

    // response backpressure on r0 with r1 waiting
    r0_rsp_ready = 1'b0;
    issue(1'b0, 32'd3, 32'hFFFF_FFFD, 2'd0, 32'd0);
    r1_valid = 1'b1; r1_a = 32'd1; r1_b = 32'd2; r1_op = 2'd0;
    e1 = 32'd3;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rspv", r0_rsp_valid, 1);
      check("bp_y", rsp_y, 0);
      check("bp_z", rsp_z, 1);
      check("bp_r1_ready", r1_ready, 0);
      cyc();
    end
    r0_rsp_ready = 1'b1;
    #1;
    check("bp_hs_r1_ready", r1_ready, 0);
    cyc();
    #1;
    check("bp_after_r1_ready", r1_ready, 1);
    cyc();
    r1_valid = 1'b0;
    drain(3);

    // op 3 back-to-back from lone r1
    grants.delete();
    r1_valid = 1'b1; r1_a = 32'h1000; r1_b = 32'h24; r1_op = 2'd3;
    e1 = 32'h1024;
    drain(6);
    r1_valid = 1'b0;
    check("b2b_count", grants.size(), 2);
    for (int i = 0; i < grants.size(); i++)
      check("b2b_owner", grants[i], 1);
    drain(2);

    // reset during MUL execution
    issue(1'b1, 32'd3, 32'd4, 2'd1, 32'd12);
    cyc();
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_ready", {r1_ready, r0_ready}, 0);
    check("mrst_rspv", {r1_rsp_valid, r0_rsp_valid}, 0);
    check("mrst_alu_a", alu_a, 0);
    check("mrst_alu_b", alu_b, 0);
    check("mrst_alu_op", alu_op, 0);
    check("mrst_rsp", {rsp_y, rsp_z}, 0);
    sb.delete();
    seen = 1'b0;
    drain(2);
    rst_n = 1'b1;
    issue(1'b1, 32'd6, 32'd7, 2'd0, 32'd13);
    drain(4);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single combinational ALU (ADD/MUL/PASS/ADDR_ADD) between two requesters, e.g. the execute stage (requester 0) and the address-generation unit (requester 1). It performs round-robin arbitration with a valid/ready request handshake and holds the ALU operands stable for a configurable number of cycles on MUL, so the multiplier path can be multicycle. Results are captured into a response register and returned to the owning requester with its own valid/ready handshake. One operation is outstanding at a time.

## Interface
- WIDTH, 32, operand/result width
- MUL_CYCLES, 2, cycles ALU inputs are held for op 1 (MUL) before capture; legal range 1..15

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- r0_valid / r1_valid  in  1  request valid, requester 0/1
- r0_ready / r1_ready  out  1  request accepted this cycle
- r0_a, r0_b / r1_a, r1_b  in  WIDTH  operands
- r0_op / r1_op  in  2  ALU opcode (0 ADD, 1 MUL, 2 PASS B, 3 ADDR_ADD)
- r0_rsp_valid / r1_rsp_valid  out  1  result valid for that requester
- r0_rsp_ready / r1_rsp_ready  in  1  requester consumes result
- rsp_y  out  WIDTH  result, shared by both requesters
- rsp_z  out  1  zero flag of the result
- alu_a, alu_b  out  WIDTH  registered operands to the ALU
- alu_op  out  2  registered opcode to the ALU
- alu_y  in  WIDTH  ALU result
- alu_z  in  1  ALU zero flag
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - If no request is valid, stay in IDLE.
  - If only one request is valid, grant that requester.
  - If both are valid, grant the requester pointed to by rr_ptr.
  - rN_ready is combinational: high only in IDLE for the granted requester. At most one ready is high per cycle.
- On accept:
  - Register a, b and op into alu_a, alu_b and alu_op.
  - Record the owner.
  - Load cnt = MUL_CYCLES-1 if op==1, else 0.
  - Go to EXEC.
- EXEC:
  - alu_* are held constant.
  - If cnt==0, capture alu_y into rsp_y and alu_z into rsp_z, set the owner's rsp_valid, and go to RESP.
  - Otherwise decrement cnt.
- RESP:
  - The owner's rsp_valid, rsp_y and rsp_z are held until the owner's rsp_ready is high.
  - On that handshake: clear rsp_valid, set rr_ptr to the non-owner, go to IDLE.
  - The non-owner's rsp_ready is ignored.
- Ops 0 and 3 are identical additions. Arithmetic is the ALU's, modulo 2^WIDTH; MUL returns the low WIDTH bits. The block does not recompute or inspect results.
- alu_a, alu_b and alu_op change only on accept. They retain their last value in IDLE and RESP.
- rr_ptr changes only on response completion. A lone requester can therefore be served back-to-back regardless of rr_ptr.
- Reset (asynchronous, any state, including mid-EXEC or RESP):
  - state = IDLE, rr_ptr = 0, cnt = 0.
  - All outputs are 0: ready, rsp_valid, rsp_y, rsp_z, alu_a, alu_b, alu_op, busy.
  - In-flight operations are discarded.

## Timing
- Accept handshake at edge T (valid and ready both high).
- Non-MUL: rsp_valid is high from cycle T+2.
- MUL: rsp_valid is high from cycle T+1+MUL_CYCLES.
- With rsp_ready held high, rsp_valid is high for exactly one cycle. The next request can be accepted the cycle after the response handshake.
- Minimum issue interval is 3 cycles for non-MUL ops and 2+MUL_CYCLES for MUL.
- A requester may raise valid while busy. It must hold valid and its operands stable until ready. The block never drops a pending request.
- Deasserting rsp_ready stalls the block in RESP indefinitely, and the other requester waits.
- alu_y and alu_z are sampled only at the cnt==0 EXEC edge.

## Test plan
- Reset, single ADD:
  - Stimulus: after reset, r0 requests 5+7, op 0; r0_rsp_ready=1.
  - Required: r0_ready is high in cycle 0; r0_rsp_valid is high in cycle 2 only; rsp_y=12, rsp_z=0; r1_rsp_valid stays 0.
- MUL latency with MUL_CYCLES=3:
  - Stimulus: r1 requests 0x10000 × 0x10000, op 1.
  - Required: alu_a, alu_b and alu_op are stable for 3 EXEC cycles; rsp_valid is high at T+4; rsp_y=0 (truncated); rsp_z=1.
- Contention round-robin:
  - Stimulus: r0 and r1 both hold valid continuously, with distinct ops (r0: PASS b=0xAB, r1: ADD 1+1).
  - Required: grants are r0, r1, r0, r1, …; responses are 0xAB and 2 to the correct owners; neither requester is starved.
- Response backpressure:
  - Stimulus: r0 ADD 3+(-3) with r0_rsp_ready=0 for 5 cycles, r1 valid throughout.
  - Required: r0_rsp_valid is held with rsp_y=0 and rsp_z=1; r1_ready stays 0 until one cycle after the r0 response handshake.
- Op 3 equivalence and lone-requester back-to-back:
  - Stimulus: r1 issues op 3 0x1000+0x24 twice with r0 idle.
  - Required: both results are 0x1024; r1 is accepted both times.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during EXEC of a MUL.
  - Required: all outputs go to 0 immediately. After release, a new r1 request completes normally and no stale response appears.
